// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder (with helper cell full_adder)
// Purpose  : Bit-serial WIDTH-bit adder. A single full_adder cell plus a carry
//            flop processes one operand bit per clock, LSB first. A start/done
//            handshake accepts operands and returns a registered sum/carry.
// Ports    : clk   - clock, all state updates on the rising edge
//            rst   - synchronous active-high reset (priority over start)
//            start - request, sampled only in IDLE or DONE
//            a, b  - WIDTH-bit operands, captured on an accepted start
//            cin   - carry-in, captured on an accepted start
//            busy  - high while bits are being processed (SHIFT)
//            done  - one-cycle pulse, sum/cout were just updated
//            sum   - result register, holds until the next completion
//            cout  - final carry, holds until the next completion
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               fa_s;
  logic               fa_c;
  logic [WIDTH-1:0]   acc_shift;
  logic               last_bit;

  full_adder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // New sum bits enter at the MSB; after WIDTH shifts the LSB-first stream
  // lines up with bit 0. A one-bit accumulator is just the adder output.
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign acc_shift = fa_s;
    end else begin : g_acc_wn
      assign acc_shift = {fa_s, acc_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_shift;
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d   = acc_shift;
          cout_d  = fa_c;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

`default_nettype wire
